// File: rtl/keypad_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator_if
// Description : Key-code push handshake between an injector (master) and the
//               keypad emulator (slave). A code transfers on a clock edge
//               where in_valid and in_ready are both high.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_emulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_code;

  // Injector side: offers codes, observes back-pressure
  modport master (
    output in_valid,
    output in_code,
    input  in_ready
  );

  // Emulator side: accepts codes, signals room in its queue
  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : Keypad-side counterpart of a 4x4 matrix scanner. Queued key
//               codes {row[1:0], col[1:0]} are replayed in order: each key
//               pulls its column low while the scanner drives its row, for
//               HOLD_SCANS row scans, then stays released for GAP_SCANS row
//               scans before the next key is taken from the 4-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
  parameter logic [7:0] HOLD_SCANS = 8'd2,
  parameter logic [7:0] GAP_SCANS  = 8'd2
) (
  input  logic             clk,
  input  logic             rst,
  keypad_emulator_if.slave in_if,
  input  logic [3:0]       key_row,
  output logic [3:0]       key_col,
  output logic             busy,
  output logic             done,
  output logic [2:0]       fifo_level
);

  // A zero count would make a key vanish without ever being seen, so the
  // smallest meaningful hold/gap is one scan.
  localparam logic [7:0] HOLD_EFF   = (HOLD_SCANS == 8'd0) ? 8'd1 : HOLD_SCANS;
  localparam logic [7:0] GAP_EFF    = (GAP_SCANS  == 8'd0) ? 8'd1 : GAP_SCANS;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [2:0] FIFO_FULL  = 3'd4;
  localparam logic [7:0] CNT_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and next-state values
  // --------------------------------------------------------------------------
  state_t     state_q,    state_d;
  logic [3:0] fifo_mem_q [FIFO_DEPTH];
  logic [3:0] fifo_mem_d [FIFO_DEPTH];
  logic [1:0] wr_ptr_q,   wr_ptr_d;
  logic [1:0] rd_ptr_q,   rd_ptr_d;
  logic [2:0] level_q,    level_d;
  logic [3:0] tgt_q,      tgt_d;
  logic [7:0] scan_cnt_q, scan_cnt_d;
  logic       hit_q,      hit_d;
  logic       done_q,     done_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       push;
  logic       pop;
  logic       match;
  logic       hit;
  logic [3:0] row_onehot;
  logic [3:0] col_onehot;
  logic [7:0] cnt_inc_sat;

  // Queue room depends only on the stored level; there is no bypass path.
  assign in_if.in_ready = (level_q < FIFO_FULL);
  assign fifo_level     = level_q;
  assign busy           = (state_q != ST_IDLE) || (level_q != 3'd0);
  assign done           = done_q;

  // Decode the target key and detect the start of each target-row scan
  always_comb begin
    // Row r and column c sit on bit (3-r) / (3-c) of their buses.
    row_onehot  = 4'b1000 >> tgt_q[3:2];
    col_onehot  = 4'b1000 >> tgt_q[1:0];
    // A non-one-hot row can never equal a one-hot pattern, so it never matches.
    match       = (key_row == row_onehot);
    // Only the first cycle of a target-row window counts as a scan.
    hit         = match && !hit_q;
    cnt_inc_sat = (scan_cnt_q == CNT_MAX) ? scan_cnt_q : (scan_cnt_q + 8'd1);
    push        = in_if.in_valid && in_if.in_ready;
    pop         = (state_q == ST_IDLE) && (level_q != 3'd0);
  end

  // Column sense: pull the target column low only while its row is driven
  always_comb begin
    key_col = 4'b1111;
    if ((state_q == ST_PRESS) && match) begin
      key_col = ~col_onehot;
    end
  end

  // Code FIFO: write at wr_ptr, read at rd_ptr, level tracks occupancy
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = in_if.in_code;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  // Press / release sequencing, scan counting and completion pulse
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    scan_cnt_d = scan_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q != 3'd0) begin
          tgt_d      = fifo_mem_q[rd_ptr_q];
          scan_cnt_d = 8'd0;
          state_d    = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (hit) begin
          scan_cnt_d = cnt_inc_sat;
        end else if ((scan_cnt_q >= HOLD_EFF) && !match) begin
          // Leaving only outside the target row keeps a press window whole.
          scan_cnt_d = 8'd0;
          state_d    = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (hit) begin
          scan_cnt_d = cnt_inc_sat;
          if (scan_cnt_q >= (GAP_EFF - 8'd1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        scan_cnt_d = 8'd0;
      end
    endcase
    // Edge memory is cleared around IDLE so that a row already sitting on the
    // target when a new key starts is still counted as a fresh scan.
    hit_d = ((state_q == ST_IDLE) || (state_d == ST_IDLE)) ? 1'b0 : match;
  end

  // State register with synchronous reset; reset drops any key mid-press
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 4'd0;
      end
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      level_q    <= 3'd0;
      tgt_q      <= 4'd0;
      scan_cnt_q <= 8'd0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tgt_q      <= tgt_d;
      scan_cnt_q <= scan_cnt_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Self-checking bench. Two emulators (HOLD/GAP = 2/2 and 0/0,
//               the latter behaving as 1/1) share stimulus; a queue-based
//               reference model predicts every output on every cycle, and
//               scripted scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  localparam int PH_IDLE = 0, PH_PRESS = 1, PH_RELEASE = 2;
  localparam int RM_ROTATE = 0, RM_HOLD = 1, RM_MIX = 2;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [3:0] key_row  = 4'b1000;
  logic       tb_valid = 1'b0;
  logic [3:0] tb_code  = 4'd0;

  logic [3:0] col_a, col_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [2:0] lvl_a, lvl_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int row_mode = RM_ROTATE;
  int rot_idx  = 0;
  int cnt_low  [2] = '{0, 0};
  int cnt_done [2] = '{0, 0};

  always #5 clk = ~clk;

  keypad_emulator_if if_a ();
  keypad_emulator_if if_b ();
  assign if_a.in_valid = tb_valid;
  assign if_a.in_code  = tb_code;
  assign if_b.in_valid = tb_valid;
  assign if_b.in_code  = tb_code;

  keypad_emulator #(.HOLD_SCANS(8'd2), .GAP_SCANS(8'd2)) dut_a (
    .clk(clk), .rst(rst), .in_if(if_a.slave), .key_row(key_row),
    .key_col(col_a), .busy(busy_a), .done(done_a), .fifo_level(lvl_a));

  keypad_emulator #(.HOLD_SCANS(8'd0), .GAP_SCANS(8'd0)) dut_b (
    .clk(clk), .rst(rst), .in_if(if_b.slave), .key_row(key_row),
    .key_col(col_b), .busy(busy_b), .done(done_b), .fifo_level(lvl_b));

  // ---------------------------------------------------------------- model
  logic [3:0] mq_a [$];
  logic [3:0] mq_b [$];
  int         m_phase [2] = '{PH_IDLE, PH_IDLE};
  int         m_cnt   [2] = '{0, 0};
  logic [3:0] m_tgt   [2] = '{4'd0, 4'd0};
  bit         m_prev  [2] = '{1'b0, 1'b0};
  bit         m_done  [2] = '{1'b0, 1'b0};

  function automatic int q_size(int k);
    if (k == 0) return mq_a.size();
    return mq_b.size();
  endfunction

  function automatic logic [3:0] q_pop(int k);
    if (k == 0) return mq_a.pop_front();
    return mq_b.pop_front();
  endfunction

  task automatic q_push(int k, logic [3:0] c);
    if (k == 0) mq_a.push_back(c);
    else        mq_b.push_back(c);
  endtask

  task automatic q_clear(int k);
    if (k == 0) mq_a.delete();
    else        mq_b.delete();
  endtask

  // The scanner "sees" the key when exactly the target row is driven.
  function automatic bit is_match(int k, logic [3:0] row);
    int r;
    r = int'(m_tgt[k][3:2]);
    return ($countones(row) == 1) && (row[3 - r] == 1'b1);
  endfunction

  function automatic logic [3:0] exp_col(int k);
    logic [3:0] v;
    v = 4'b1111;
    if ((m_phase[k] == PH_PRESS) && is_match(k, key_row))
      v[3 - int'(m_tgt[k][1:0])] = 1'b0;
    return v;
  endfunction

  task automatic model_step(int k, int hold, int gap);
    int sz;
    bit mt, ht, nd;
    sz = q_size(k);
    mt = is_match(k, key_row);
    ht = mt && !m_prev[k];
    nd = 1'b0;
    if (rst) begin
      q_clear(k);
      m_phase[k] = PH_IDLE; m_cnt[k] = 0; m_tgt[k] = 4'd0;
      m_prev[k] = 1'b0; m_done[k] = 1'b0;
      return;
    end
    case (m_phase[k])
      PH_IDLE: begin
        m_prev[k] = 1'b0;
        if (sz > 0) begin
          m_tgt[k] = q_pop(k);
          m_cnt[k] = 0;
          m_phase[k] = PH_PRESS;
        end
      end
      PH_PRESS: begin
        if (ht) m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
        else if ((m_cnt[k] >= hold) && !mt) begin
          m_cnt[k] = 0;
          m_phase[k] = PH_RELEASE;
        end
        m_prev[k] = mt;
      end
      default: begin
        if (ht) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] >= gap) begin
            m_phase[k] = PH_IDLE;
            nd = 1'b1;
          end
        end
        m_prev[k] = (m_phase[k] == PH_IDLE) ? 1'b0 : mt;
      end
    endcase
    if (tb_valid && (sz < 4)) q_push(k, tb_code);
    m_done[k] = nd;
  endtask

  always @(posedge clk) begin
    model_step(0, 2, 2);
    model_step(1, 1, 1);
  end

  // ---------------------------------------------------------------- checking
  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare_one(int k, logic [3:0] col, logic rdy, logic bsy,
                             logic dn, logic [2:0] lvl);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, ".key_col"},    8'(col), 8'(exp_col(k)));
    chk({p, ".in_ready"},   8'(rdy), 8'(q_size(k) < 4));
    chk({p, ".fifo_level"}, 8'(lvl), 8'(q_size(k)));
    chk({p, ".busy"},       8'(bsy), 8'((m_phase[k] != PH_IDLE) || (q_size(k) != 0)));
    chk({p, ".done"},       8'(dn),  8'(m_done[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_one(0, col_a, if_a.in_ready, busy_a, done_a, lvl_a);
      compare_one(1, col_b, if_b.in_ready, busy_b, done_b, lvl_b);
    end
    if (col_a !== 4'b1111) cnt_low[0]++;
    if (col_b !== 4'b1111) cnt_low[1]++;
    if (done_a === 1'b1)   cnt_done[0]++;
    if (done_b === 1'b1)   cnt_done[1]++;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk); #1;
    case (row_mode)
      RM_ROTATE: begin
        key_row = 4'b1000 >> rot_idx;
        rot_idx = (rot_idx + 1) % 4;
      end
      RM_MIX: begin
        if ($urandom_range(0, 4) == 0) key_row = 4'($urandom);
        else begin
          key_row = 4'b1000 >> rot_idx;
          rot_idx = (rot_idx + 1) % 4;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push(logic [3:0] c);
    tb_valid = 1'b1;
    tb_code  = c;
    tick();
    tb_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clr_counts();
    cnt_low  = '{0, 0};
    cnt_done = '{0, 0};
  endtask

  task automatic wait_idle(int limit, string name);
    int n;
    n = 0;
    do begin
      tick();
      settle();
      n++;
    end while ((busy_a || busy_b) && (n < limit));
    chk({name, ".drain_timeout"}, 8'(busy_a || busy_b), 8'h00);
  endtask

  initial begin
    // Reset with rows rotating
    rst = 1'b1;
    row_mode = RM_ROTATE;
    tick(); tick();
    settle();
    chk("reset.key_col_a", 8'(col_a), 8'h0F);
    chk("reset.key_col_b", 8'(col_b), 8'h0F);
    chk("reset.in_ready",  8'(if_a.in_ready), 8'h01);
    chk("reset.busy",      8'(busy_a), 8'h00);
    chk("reset.done",      8'(done_a), 8'h00);
    chk("reset.level",     8'(lvl_a), 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single key 0x6 with rotating rows
    clr_counts();
    push(4'h6);
    wait_idle(200, "single");
    chk("single.press_cycles_a", 8'(cnt_low[0]), 8'd2);
    chk("single.press_cycles_b", 8'(cnt_low[1]), 8'd1);
    chk("single.done_a", 8'(cnt_done[0]), 8'd1);
    chk("single.done_b", 8'(cnt_done[1]), 8'd1);

    // Queue full: first key parked in PRESS (no rows driven), 6 more offered
    key_row = 4'b0000;
    row_mode = RM_HOLD;
    push(4'h9);
    tick(); tick();
    tb_code = 4'h1; tb_valid = 1'b1; tick();
    tb_code = 4'h2; tick();
    tb_code = 4'h3; tick();
    tb_code = 4'hA; tick();
    tb_code = 4'hB; tick();
    tb_code = 4'hC; tick();
    tb_valid = 1'b0;
    settle();
    chk("full.level_a", 8'(lvl_a), 8'd4);
    chk("full.ready_a", 8'(if_a.in_ready), 8'd0);
    chk("full.level_b", 8'(lvl_b), 8'd4);
    chk("full.ready_b", 8'(if_b.in_ready), 8'd0);
    clr_counts();
    row_mode = RM_ROTATE;
    wait_idle(400, "full");
    chk("full.done_a", 8'(cnt_done[0]), 8'd5);
    chk("full.done_b", 8'(cnt_done[1]), 8'd5);

    // Stuck row on key 0x5, then illegal rows
    key_row = 4'b0100;
    row_mode = RM_HOLD;
    push(4'h5);
    repeat (20) tick();
    settle();
    chk("stuck.key_col_a", 8'(col_a), 8'h0B);
    chk("stuck.key_col_b", 8'(col_b), 8'h0B);
    chk("stuck.busy_a", 8'(busy_a), 8'h01);
    key_row = 4'b0110;
    tick(); settle();
    chk("illegal0110.key_col_a", 8'(col_a), 8'h0F);
    key_row = 4'b0000;
    tick(); settle();
    chk("illegal0000.key_col_a", 8'(col_a), 8'h0F);
    row_mode = RM_ROTATE;
    wait_idle(200, "stuck");

    // Corner code 0xF on row 0001
    key_row = 4'b0001;
    row_mode = RM_HOLD;
    push(4'hF);
    tick(); tick();
    settle();
    chk("corner_f.key_col_a", 8'(col_a), 8'h0E);
    chk("corner_f.key_col_b", 8'(col_b), 8'h0E);
    row_mode = RM_ROTATE;
    wait_idle(200, "corner_f");

    // Corner code 0x0 with rotation; HOLD=0 instance must press for one scan
    clr_counts();
    push(4'h0);
    wait_idle(200, "corner_0");
    chk("corner_0.press_cycles_a", 8'(cnt_low[0]), 8'd2);
    chk("corner_0.press_cycles_b", 8'(cnt_low[1]), 8'd1);

    // Reset while key 0x0 is pressed with more codes queued
    key_row = 4'b1000;
    row_mode = RM_HOLD;
    push(4'h0); push(4'h3); push(4'h9);
    tick();
    settle();
    chk("midreset.key_col_before", 8'(col_a), 8'h07);
    chk("midreset.level_before",   8'(lvl_a), 8'd2);
    clr_counts();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("midreset.key_col_after", 8'(col_a), 8'h0F);
    chk("midreset.level_after",   8'(lvl_a), 8'd0);
    chk("midreset.busy_after",    8'(busy_b), 8'd0);
    repeat (3) tick();
    settle();
    chk("midreset.no_done", 8'(cnt_done[0] + cnt_done[1]), 8'd0);

    // Randomized traffic with occasional illegal / random row patterns
    row_mode = RM_MIX;
    for (int i = 0; i < 400; i++) begin
      tb_valid = ($urandom_range(0, 2) == 0);
      tb_code  = 4'($urandom);
      tick();
    end
    tb_valid = 1'b0;
    row_mode = RM_ROTATE;
    wait_idle(600, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
